// File: rtl/hazard_ctrl_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl_unit_pkg
// Brief    : Shared encodings, stage payload types and helpers for the
//            five-stage pipeline hazard/control unit.
// Revision : 1.0 - initial release
// ============================================================================
package hazard_ctrl_unit_pkg;

    // Decoded ALU class carried down the pipeline
    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_e;

    // Execute-stage operand source select
    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_e;

    localparam logic [4:0]  REG_ZERO      = 5'd0;
    localparam logic [15:0] STALL_CNT_MAX = 16'hFFFF;

    // Payload held in the D->E register
    typedef struct packed {
        logic       reg_write;
        logic       mem_write;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic       alu_src_b;
        logic       reg_dst;
        aluop_e     alu_op;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
    } e_stage_t;

    // Payload held in the E->M register
    typedef struct packed {
        logic       reg_write;
        logic       mem_write;
        logic       mem_to_reg;
        logic [4:0] write_reg;
    } m_stage_t;

    // Payload held in the M->W register
    typedef struct packed {
        logic       reg_write;
        logic       mem_to_reg;
        logic [4:0] write_reg;
    } w_stage_t;

    // True when a qualified writer targets a real (non-zero) source register
    function automatic logic f_reg_hit(input logic       i_qual,
                                       input logic [4:0] i_dst,
                                       input logic [4:0] i_src);
        return i_qual && (i_dst != REG_ZERO) && (i_dst == i_src);
    endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_ctrl_unit_ctrl_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_stage_reg
// Brief    : Generic pipeline stage register with enable, synchronous clear
//            (bubble insertion) and asynchronous active-low reset.
// Revision : 1.0 - initial release
// ============================================================================
module ctrl_stage_reg
    import hazard_ctrl_unit_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    input  logic             i_clr,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    // Clear wins over enable so a flushed stage always becomes a bubble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (i_clr) begin
            r_q <= '0;
        end else if (i_en) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl_unit.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl_unit
// Brief    : Stages decoded control through E/M/W, detects load-use and
//            branch-compare hazards, drives stall/flush/forward selects and
//            keeps a saturating count of stall cycles.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_ctrl_unit
    import hazard_ctrl_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RegWriteD,
    input  logic        MemWriteD,
    input  logic        MemToRegD,
    input  logic        ALUSrcAD,
    input  logic        ALUSrcBD,
    input  logic        RegDstD,
    input  logic        BranchD,
    input  logic [1:0]  ALUOpD,
    input  logic [4:0]  RsD,
    input  logic [4:0]  RtD,
    input  logic [4:0]  RdD,
    input  logic        BranchTakenD,
    output logic        StallF,
    output logic        StallD,
    output logic        FlushD,
    output logic        FlushE,
    output logic [1:0]  ForwardAE,
    output logic [1:0]  ForwardBE,
    output logic        ForwardAD,
    output logic        ForwardBD,
    output logic        RegWriteE,
    output logic        RegWriteM,
    output logic        RegWriteW,
    output logic        MemToRegE,
    output logic        MemToRegM,
    output logic        MemToRegW,
    output logic        MemWriteE,
    output logic        MemWriteM,
    output logic        ALUSrcAE,
    output logic        ALUSrcBE,
    output logic [1:0]  ALUOpE,
    output logic [4:0]  RsE,
    output logic [4:0]  RtE,
    output logic [4:0]  WriteRegE,
    output logic [4:0]  WriteRegM,
    output logic [4:0]  WriteRegW,
    output logic [15:0] StallCount
);

    e_stage_t    w_e_d;
    e_stage_t    r_e;
    m_stage_t    w_m_d;
    m_stage_t    r_m;
    w_stage_t    w_w_d;
    w_stage_t    r_w;
    logic [4:0]  w_write_reg_e;
    logic        w_lwstall;
    logic        w_branchstall;
    logic        w_stall;
    logic [15:0] r_stall_cnt;

    // Assemble the next contents of each stage register
    always_comb begin
        w_e_d = '{reg_write:  RegWriteD,
                  mem_write:  MemWriteD,
                  mem_to_reg: MemToRegD,
                  alu_src_a:  ALUSrcAD,
                  alu_src_b:  ALUSrcBD,
                  reg_dst:    RegDstD,
                  alu_op:     aluop_e'(ALUOpD),
                  rs:         RsD,
                  rt:         RtD,
                  rd:         RdD};
        w_write_reg_e = r_e.reg_dst ? r_e.rd : r_e.rt;
        w_m_d = '{reg_write:  r_e.reg_write,
                  mem_write:  r_e.mem_write,
                  mem_to_reg: r_e.mem_to_reg,
                  write_reg:  w_write_reg_e};
        w_w_d = '{reg_write:  r_m.reg_write,
                  mem_to_reg: r_m.mem_to_reg,
                  write_reg:  r_m.write_reg};
    end

    // A stall freezes D, so E receives a bubble rather than the held instruction
    ctrl_stage_reg #(.WIDTH($bits(e_stage_t))) u_reg_e (
        .clk   (clk),
        .rst_n (rst_n),
        .i_en  (~w_stall),
        .i_clr (w_stall),
        .i_d   (w_e_d),
        .o_q   (r_e)
    );

    ctrl_stage_reg #(.WIDTH($bits(m_stage_t))) u_reg_m (
        .clk   (clk),
        .rst_n (rst_n),
        .i_en  (1'b1),
        .i_clr (1'b0),
        .i_d   (w_m_d),
        .o_q   (r_m)
    );

    ctrl_stage_reg #(.WIDTH($bits(w_stage_t))) u_reg_w (
        .clk   (clk),
        .rst_n (rst_n),
        .i_en  (1'b1),
        .i_clr (1'b0),
        .i_d   (w_w_d),
        .o_q   (r_w)
    );

    // Load-use and branch-compare hazards; r0 is never a real dependency
    always_comb begin
        w_lwstall = r_e.mem_to_reg && (r_e.rt != REG_ZERO) &&
                    ((r_e.rt == RsD) || (r_e.rt == RtD));
        w_branchstall = BranchD &&
                        (f_reg_hit(r_e.reg_write,  w_write_reg_e, RsD) ||
                         f_reg_hit(r_e.reg_write,  w_write_reg_e, RtD) ||
                         f_reg_hit(r_m.mem_to_reg, r_m.write_reg, RsD) ||
                         f_reg_hit(r_m.mem_to_reg, r_m.write_reg, RtD));
        w_stall = w_lwstall || w_branchstall;
    end

    // Forwarding selects; the younger M result takes priority over W
    always_comb begin
        ForwardAE = FWD_RF;
        ForwardBE = FWD_RF;
        if (f_reg_hit(r_m.reg_write, r_m.write_reg, r_e.rs)) begin
            ForwardAE = FWD_M;
        end else if (f_reg_hit(r_w.reg_write, r_w.write_reg, r_e.rs)) begin
            ForwardAE = FWD_W;
        end
        if (f_reg_hit(r_m.reg_write, r_m.write_reg, r_e.rt)) begin
            ForwardBE = FWD_M;
        end else if (f_reg_hit(r_w.reg_write, r_w.write_reg, r_e.rt)) begin
            ForwardBE = FWD_W;
        end
        ForwardAD = f_reg_hit(r_m.reg_write, r_m.write_reg, RsD);
        ForwardBD = f_reg_hit(r_m.reg_write, r_m.write_reg, RtD);
    end

    // Saturating count of cycles in which decode was held
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != STALL_CNT_MAX)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign StallF     = w_stall;
    assign StallD     = w_stall;
    assign FlushE     = w_stall;
    assign FlushD     = BranchD && BranchTakenD && !w_stall;
    assign StallCount = r_stall_cnt;

    assign RegWriteE  = r_e.reg_write;
    assign MemToRegE  = r_e.mem_to_reg;
    assign MemWriteE  = r_e.mem_write;
    assign ALUSrcAE   = r_e.alu_src_a;
    assign ALUSrcBE   = r_e.alu_src_b;
    assign ALUOpE     = r_e.alu_op;
    assign RsE        = r_e.rs;
    assign RtE        = r_e.rt;
    assign WriteRegE  = w_write_reg_e;

    assign RegWriteM  = r_m.reg_write;
    assign MemToRegM  = r_m.mem_to_reg;
    assign MemWriteM  = r_m.mem_write;
    assign WriteRegM  = r_m.write_reg;

    assign RegWriteW  = r_w.reg_write;
    assign MemToRegW  = r_w.mem_to_reg;
    assign WriteRegW  = r_w.write_reg;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_ctrl_unit
// Brief    : Self-checking bench for hazard_ctrl_unit: instruction-history
//            reference model compared every cycle plus directed literal checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl_unit;

    typedef struct {
        logic       rw, mw, mtr, asa, asb, rdst, br, bt;
        logic [1:0] op;
        logic [4:0] rs, rt, rd;
    } instr_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic RegWriteD, MemWriteD, MemToRegD, ALUSrcAD, ALUSrcBD, RegDstD, BranchD, BranchTakenD;
    logic [1:0] ALUOpD;
    logic [4:0] RsD, RtD, RdD;
    logic StallF, StallD, FlushD, FlushE, ForwardAD, ForwardBD;
    logic [1:0] ForwardAE, ForwardBE, ALUOpE;
    logic RegWriteE, RegWriteM, RegWriteW, MemToRegE, MemToRegM, MemToRegW;
    logic MemWriteE, MemWriteM, ALUSrcAE, ALUSrcBE;
    logic [4:0] RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
    logic [15:0] StallCount;

    int n_checks = 0;
    int n_pass   = 0;

    instr_t      dcur;
    instr_t      hist[$];   // hist[0]=E, hist[1]=M, hist[2]=W
    logic [15:0] m_cnt = 16'd0;

    always #5 clk = ~clk;

    hazard_ctrl_unit dut (
        .clk(clk), .rst_n(rst_n),
        .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .MemToRegD(MemToRegD),
        .ALUSrcAD(ALUSrcAD), .ALUSrcBD(ALUSrcBD), .RegDstD(RegDstD), .BranchD(BranchD),
        .ALUOpD(ALUOpD), .RsD(RsD), .RtD(RtD), .RdD(RdD), .BranchTakenD(BranchTakenD),
        .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
        .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .MemToRegE(MemToRegE), .MemToRegM(MemToRegM), .MemToRegW(MemToRegW),
        .MemWriteE(MemWriteE), .MemWriteM(MemWriteM), .ALUSrcAE(ALUSrcAE), .ALUSrcBE(ALUSrcBE),
        .ALUOpE(ALUOpE), .RsE(RsE), .RtE(RtE),
        .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
        .StallCount(StallCount)
    );

    // ---------------- instruction constructors ----------------
    function automatic instr_t f_nop();
        instr_t t;
        t = '{default: '0};
        return t;
    endfunction

    function automatic instr_t f_lw(input int rt, input int rs);
        instr_t t = f_nop();
        t.rw = 1; t.mtr = 1; t.asb = 1; t.op = 2'b00; t.rs = 5'(rs); t.rt = 5'(rt);
        return t;
    endfunction

    function automatic instr_t f_alu(input int rd, input int rs, input int rt);
        instr_t t = f_nop();
        t.rw = 1; t.rdst = 1; t.op = 2'b10; t.rs = 5'(rs); t.rt = 5'(rt); t.rd = 5'(rd);
        return t;
    endfunction

    function automatic instr_t f_beq(input int rs, input int rt, input logic taken);
        instr_t t = f_nop();
        t.br = 1; t.bt = taken; t.op = 2'b01; t.rs = 5'(rs); t.rt = 5'(rt);
        return t;
    endfunction

    // ---------------- reference model ----------------
    function automatic logic [4:0] m_dst(input instr_t t);
        return t.rdst ? t.rd : t.rt;
    endfunction

    function automatic logic m_hit(input logic q, input logic [4:0] dst, input logic [4:0] src);
        return q && (dst != 5'd0) && (dst == src);
    endfunction

    // Instruction occupying stage k (0=E, 1=M, 2=W); nothing survives reset
    function automatic instr_t stg(input int k);
        if (!rst_n) return f_nop();
        return hist[k];
    endfunction

    function automatic logic m_stall();
        instr_t e = stg(0);
        instr_t m = stg(1);
        logic lw, br;
        lw = e.mtr && (e.rt != 5'd0) && ((e.rt == dcur.rs) || (e.rt == dcur.rt));
        br = dcur.br && (m_hit(e.rw, m_dst(e), dcur.rs) || m_hit(e.rw, m_dst(e), dcur.rt) ||
                         m_hit(m.mtr, m_dst(m), dcur.rs) || m_hit(m.mtr, m_dst(m), dcur.rt));
        return lw || br;
    endfunction

    function automatic logic [1:0] m_fwd_e(input logic [4:0] src);
        instr_t m = stg(1);
        instr_t w = stg(2);
        if (m_hit(m.rw, m_dst(m), src)) return 2'b10;
        if (m_hit(w.rw, m_dst(w), src)) return 2'b01;
        return 2'b00;
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    // Model advance: a stall sends a bubble into E while older work moves on
    always @(posedge clk) begin
        if (!rst_n) begin
            hist  = {f_nop(), f_nop(), f_nop()};
            m_cnt = 16'd0;
        end else begin
            logic st;
            st = m_stall();
            hist.push_front(st ? f_nop() : dcur);
            void'(hist.pop_back());
            if (st && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        end
    end

    // Every-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        instr_t e, m, w;
        logic   st;
        e = stg(0); m = stg(1); w = stg(2);
        st = m_stall();
        chk("StallF", 16'(StallF), 16'(st));
        chk("StallD", 16'(StallD), 16'(st));
        chk("FlushE", 16'(FlushE), 16'(st));
        chk("FlushD", 16'(FlushD), 16'(dcur.br && dcur.bt && !st));
        chk("ForwardAE", 16'(ForwardAE), 16'(m_fwd_e(e.rs)));
        chk("ForwardBE", 16'(ForwardBE), 16'(m_fwd_e(e.rt)));
        chk("ForwardAD", 16'(ForwardAD), 16'(m_hit(m.rw, m_dst(m), dcur.rs)));
        chk("ForwardBD", 16'(ForwardBD), 16'(m_hit(m.rw, m_dst(m), dcur.rt)));
        chk("E_ctrl", 16'({RegWriteE, MemToRegE, MemWriteE, ALUSrcAE, ALUSrcBE, ALUOpE}),
            16'({e.rw, e.mtr, e.mw, e.asa, e.asb, e.op}));
        chk("E_regs", 16'({RsE, RtE, WriteRegE}), 16'({e.rs, e.rt, m_dst(e)}));
        chk("M_stage", 16'({RegWriteM, MemToRegM, MemWriteM, WriteRegM}),
            16'({m.rw, m.mtr, m.mw, m_dst(m)}));
        chk("W_stage", 16'({RegWriteW, MemToRegW, WriteRegW}), 16'({w.rw, w.mtr, m_dst(w)}));
        chk("StallCount", StallCount, rst_n ? m_cnt : 16'd0);
    end

    // ---------------- stimulus ----------------
    task automatic drive(input instr_t t);
        dcur = t;
        RegWriteD = t.rw; MemWriteD = t.mw; MemToRegD = t.mtr; ALUSrcAD = t.asa;
        ALUSrcBD = t.asb; RegDstD = t.rdst; BranchD = t.br; BranchTakenD = t.bt;
        ALUOpD = t.op; RsD = t.rs; RtD = t.rt; RdD = t.rd;
    endtask

    // Present an instruction in D for one cycle; returns at that cycle's negedge
    task automatic step(input instr_t t);
        @(posedge clk);
        #1;
        drive(t);
        @(negedge clk);
    endtask

    task automatic drain(input int n);
        repeat (n) step(f_nop());
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        hist = {f_nop(), f_nop(), f_nop()};
        drive(f_nop());
        @(negedge clk);
        chk("reset_StallCount", StallCount, 16'd0);
        chk("reset_RegWriteW", 16'(RegWriteW), 16'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Load-use: one stall, bubble, then W forwarding
        step(f_lw(2, 1));
        step(f_alu(3, 2, 4));
        chk("lu_StallD", 16'(StallD), 16'd1);
        chk("lu_FlushE", 16'(FlushE), 16'd1);
        step(f_alu(3, 2, 4));
        chk("lu_bubbleE", 16'({RegWriteE, MemToRegE}), 16'd0);
        chk("lu_StallD_clear", 16'(StallD), 16'd0);
        step(f_nop());
        chk("lu_ForwardAE", 16'(ForwardAE), 16'b01);
        chk("lu_StallCount", StallCount, 16'd1);
        drain(3);

        // Back-to-back ALU: forward from M on both operands
        step(f_alu(5, 1, 1));
        step(f_alu(6, 5, 5));
        chk("alu_nostall", 16'(StallD), 16'd0);
        step(f_nop());
        chk("alu_ForwardAE", 16'(ForwardAE), 16'b10);
        chk("alu_ForwardBE", 16'(ForwardBE), 16'b10);
        drain(3);

        // M beats W for the same register; rt=r0 never forwards
        step(f_alu(5, 1, 1));
        step(f_alu(5, 2, 2));
        step(f_alu(7, 5, 0));
        step(f_nop());
        chk("prio_ForwardAE", 16'(ForwardAE), 16'b10);
        chk("prio_ForwardBE", 16'(ForwardBE), 16'b00);
        drain(3);

        // Branch depends on ALU result in E
        step(f_alu(8, 1, 1));
        step(f_beq(8, 0, 1'b1));
        chk("br_StallD", 16'(StallD), 16'd1);
        chk("br_FlushD_held", 16'(FlushD), 16'd0);
        step(f_beq(8, 0, 1'b1));
        chk("br_ForwardAD", 16'(ForwardAD), 16'd1);
        chk("br_FlushD", 16'(FlushD), 16'd1);
        chk("br_StallCount", StallCount, 16'd2);
        drain(3);

        // r0 writes/reads: no stall, no forwarding
        step(f_alu(0, 1, 1));
        step(f_alu(9, 0, 0));
        chk("r0_nostall", 16'(StallD), 16'd0);
        step(f_lw(0, 1));
        chk("r0_ForwardE", 16'({ForwardAE, ForwardBE}), 16'd0);
        step(f_alu(10, 0, 0));
        chk("r0_lw_nostall", 16'(StallD), 16'd0);
        step(f_beq(0, 0, 1'b0));
        chk("r0_br_nostall", 16'(StallD), 16'd0);
        chk("r0_ForwardD", 16'({ForwardAD, ForwardBD}), 16'd0);
        drain(3);

        // Load feeding a branch: two stall cycles (E then M)
        step(f_lw(11, 1));
        step(f_beq(11, 0, 1'b0));
        step(f_beq(11, 0, 1'b0));
        chk("ldbr_second_stall", 16'(StallD), 16'd1);
        step(f_beq(11, 0, 1'b0));
        chk("ldbr_StallCount", StallCount, 16'd4);
        drain(3);

        // Reset asserted mid-stall
        step(f_lw(2, 1));
        step(f_alu(3, 2, 4));
        chk("rst_pre_stall", 16'(StallD), 16'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_StallCount", StallCount, 16'd0);
        chk("rst_E_ctrl", 16'({RegWriteE, MemToRegE}), 16'd0);
        chk("rst_StallD", 16'(StallD), 16'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        drain(3);

        // Sustained 2-of-3 stall pattern until the counter saturates
        for (int i = 0; i < 32770; i++) begin
            step(f_lw(2, 1));
            step(f_beq(2, 0, 1'b0));
            step(f_beq(2, 0, 1'b0));
        end
        step(f_nop());
        chk("sat_StallCount", StallCount, 16'hFFFF);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
